// File: rtl/zeroriscy_prefetch_buffer_mo_if.sv
// Instruction-memory bus between the prefetch buffer and the memory or cache.
//   master : the prefetch buffer. It drives instr_req/instr_addr and samples the
//            grant/response signals.
//   slave  : the memory side.
// Signals: instr_req, instr_gnt, instr_addr[31:0], instr_rdata[31:0], instr_rvalid,
//          and instr_err (present only when ZR_PREFETCH_ERR_EN is defined).
interface zeroriscy_prefetch_buffer_mo_if;
    logic        instr_req;
    logic        instr_gnt;
    logic [31:0] instr_addr;
    logic [31:0] instr_rdata;
    logic        instr_rvalid;
`ifdef ZR_PREFETCH_ERR_EN
    logic        instr_err;

    modport master (output instr_req, instr_addr,
                    input  instr_gnt, instr_rdata, instr_rvalid, instr_err);
    modport slave  (input  instr_req, instr_addr,
                    output instr_gnt, instr_rdata, instr_rvalid, instr_err);
`else
    modport master (output instr_req, instr_addr,
                    input  instr_gnt, instr_rdata, instr_rvalid);
    modport slave  (input  instr_req, instr_addr,
                    output instr_gnt, instr_rdata, instr_rvalid);
`endif
endinterface

// File: rtl/zeroriscy_prefetch_buffer_mo.sv
// Multi-outstanding instruction prefetch buffer.
// Up to NUM_REQS granted fetches can be in flight at once. Returned words go into a
// DEPTH-entry FIFO together with their addresses. A branch flushes the FIFO, and any
// responses still in flight are dropped as they arrive.
// Optional feature macro: ZR_PREFETCH_ERR_EN. It adds per-entry error tracking and the
// err_o output.
// Ports:
//   clk, rst_n           clock and asynchronous active-low reset
//   req_i                core wants instructions
//   branch_i, addr_i     one-cycle redirect of the fetch stream to addr_i
//   ready_i              core takes the FIFO head this cycle
//   valid_o, rdata_o,
//   addr_o               FIFO head: valid flag, instruction word, word address
//   err_o                head entry came back with an error (ZR_PREFETCH_ERR_EN only)
//   busy_o               a request is active or responses are still due
//   bus                  instruction-memory bus, master side
module zeroriscy_prefetch_buffer_mo #(
    parameter int DEPTH    = 4,
    parameter int NUM_REQS = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic        branch_i,
    input  logic [31:0] addr_i,
    input  logic        ready_i,
    output logic        valid_o,
    output logic [31:0] rdata_o,
    output logic [31:0] addr_o,
`ifdef ZR_PREFETCH_ERR_EN
    output logic        err_o,
`endif
    output logic        busy_o,
    zeroriscy_prefetch_buffer_mo_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(NUM_REQS + 1);
    localparam int QW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;

    state_t        state_q;
    logic [31:0]   fetch_addr_q;
    logic          req_pending_q;
    logic [OW-1:0] outstanding_q, discard_q;
    logic [OW-1:0] outstanding_next, discard_next, live;
    logic [31:0]   fifo_data_q [DEPTH];
    logic [31:0]   fifo_addr_q [DEPTH];
    logic [PW-1:0] rptr_q, wptr_q;
    logic [CW-1:0] count_q;
    logic [31:0]   aq_q [NUM_REQS];
    logic [QW-1:0] aq_rptr_q, aq_wptr_q;
    logic [31:0]   branch_addr;
    logic          issue, grant, rvalid, drop, push, pop, err_block;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^addr_i[1:0];
    assign branch_addr      = {addr_i[31:2], 2'b00};
    assign live             = outstanding_q - discard_q;

    // Each live request has a FIFO slot reserved for its response. During a branch the
    // FIFO is being cleared, so its current contents do not count against the limit.
    assign issue = req_i && !err_block && (int'(outstanding_q) < NUM_REQS) &&
                   (((branch_i ? 0 : int'(count_q)) + int'(live)) < DEPTH);

    // Once a request is raised it stays up until it is granted. A branch only changes
    // the address it targets.
    assign bus.instr_req  = req_pending_q | issue;
    assign bus.instr_addr = branch_i ? branch_addr : fetch_addr_q;

    assign grant  = bus.instr_req & bus.instr_gnt;
    assign rvalid = bus.instr_rvalid;
    assign drop   = rvalid & (branch_i | (discard_q != '0));
    assign push   = rvalid & ~drop;
    assign pop    = ready_i & valid_o & ~branch_i;
    assign busy_o = bus.instr_req | (outstanding_q != '0);

    assign outstanding_next = outstanding_q + OW'(grant) - OW'(rvalid);
    always_comb begin
        discard_next = discard_q;
        if (branch_i)
            discard_next = outstanding_q - OW'(rvalid);
        else if (rvalid && discard_q != '0)
            discard_next = discard_q - OW'(1);
    end

    assign valid_o = (count_q != '0);
    assign rdata_o = valid_o ? fifo_data_q[rptr_q] : '0;
    assign addr_o  = valid_o ? fifo_addr_q[rptr_q] : '0;

    function automatic logic [QW-1:0] aq_inc(input logic [QW-1:0] p);
        return (p == QW'(NUM_REQS - 1)) ? '0 : p + QW'(1);
    endfunction

`ifdef ZR_PREFETCH_ERR_EN
    logic fifo_err_q [DEPTH];
    logic err_block_q;
    // A branch lifts the block in the same cycle, so the redirected fetch can issue at once.
    assign err_block = err_block_q & ~branch_i;
    assign err_o     = valid_o & fifo_err_q[rptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_block_q <= 1'b0;
        else if (branch_i)
            err_block_q <= 1'b0;
        else if (push && bus.instr_err)
            err_block_q <= 1'b1;
    end
`else
    assign err_block = 1'b0;
`endif

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_fifo
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                fifo_data_q[gi] <= '0;
                fifo_addr_q[gi] <= '0;
`ifdef ZR_PREFETCH_ERR_EN
                fifo_err_q[gi]  <= 1'b0;
`endif
            end else if (push && wptr_q == PW'(gi)) begin
                fifo_data_q[gi] <= bus.instr_rdata;
                fifo_addr_q[gi] <= aq_q[aq_rptr_q];
`ifdef ZR_PREFETCH_ERR_EN
                fifo_err_q[gi]  <= bus.instr_err;
`endif
            end
        end
    end

    // The address queue holds the address of every granted request, in grant order.
    // Responses are returned in that same order.
    for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_aq
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                aq_q[gi] <= '0;
            else if (grant && aq_wptr_q == QW'(gi))
                aq_q[gi] <= bus.instr_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_addr_q  <= '0;
            req_pending_q <= 1'b0;
            outstanding_q <= '0;
            discard_q     <= '0;
            rptr_q        <= '0;
            wptr_q        <= '0;
            count_q       <= '0;
            aq_rptr_q     <= '0;
            aq_wptr_q     <= '0;
        end else begin
            if (branch_i)
                fetch_addr_q <= grant ? branch_addr + 32'd4 : branch_addr;
            else if (grant)
                fetch_addr_q <= fetch_addr_q + 32'd4;
            req_pending_q <= bus.instr_req & ~bus.instr_gnt;
            outstanding_q <= outstanding_next;
            discard_q     <= discard_next;
            if (branch_i) begin
                rptr_q  <= '0;
                wptr_q  <= '0;
                count_q <= '0;
            end else begin
                if (push) wptr_q <= wptr_q + PW'(1);
                if (pop)  rptr_q <= rptr_q + PW'(1);
                count_q <= count_q + CW'(push) - CW'(pop);
            end
            if (grant)  aq_wptr_q <= aq_inc(aq_wptr_q);
            if (rvalid) aq_rptr_q <= aq_inc(aq_rptr_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else begin
            case (state_q)
                IDLE:    if (bus.instr_req) state_q <= FETCH;
                FETCH:   if (branch_i && outstanding_q > OW'(rvalid)) state_q <= FLUSH;
                         else if (outstanding_next == '0 && !bus.instr_req) state_q <= IDLE;
                FLUSH:   if (discard_next == '0) state_q <= FETCH;
                default: state_q <= IDLE;
            endcase
        end
    end

`ifndef SYNTHESIS
    a_rvalid_none_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
        bus.instr_rvalid |-> (outstanding_q != '0));
    a_gnt_rvalid_same_cycle: assert property (@(posedge clk) disable iff (!rst_n)
        (grant && bus.instr_rvalid) |-> (outstanding_q != '0));
`endif
endmodule

// File: tb/tb_zeroriscy_prefetch_buffer_mo.sv
module tb_zeroriscy_prefetch_buffer_mo;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_i = 1'b0, branch_i = 1'b0, ready_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic        valid_o, busy_o;
    logic [31:0] rdata_o, addr_o;
`ifdef ZR_PREFETCH_ERR_EN
    logic        err_o;
`endif
    int tests = 0;
    int failed = 0;

    zeroriscy_prefetch_buffer_mo_if bus();

    zeroriscy_prefetch_buffer_mo #(.DEPTH(4), .NUM_REQS(2)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .branch_i(branch_i), .addr_i(addr_i),
        .ready_i(ready_i), .valid_o(valid_o), .rdata_o(rdata_o), .addr_o(addr_o),
`ifdef ZR_PREFETCH_ERR_EN
        .err_o(err_o),
`endif
        .busy_o(busy_o), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic        req, br;
        logic [31:0] addr;
        logic        rdy, gnt, rv;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_iaddr;
        logic        e_busy, e_valid;
        logic [31:0] e_addr, e_rdata;
    } vec_t;
    vec_t vecs [22];

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    mreq_t mq [$];
    int cyc = 0, grants = 0, pops = 0;
    logic [31:0] exp_req_addr, exp_pop_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle with a memory that answers every grant in the following cycle.
    // The bench checks each grant address and each popped entry against its own
    // running expectations.
    task automatic auto_cycle();
        mreq_t m;
        @(negedge clk);
        if (bus.instr_rvalid) void'(mq.pop_front());
        if (bus.instr_req && bus.instr_gnt) begin
            check("grant_addr", bus.instr_addr, exp_req_addr);
            m.addr = exp_req_addr;
            m.due  = cyc + 1;
            mq.push_back(m);
            exp_req_addr += 32'd4;
            grants++;
        end
        if (valid_o && ready_i) begin
            check("pop_addr", addr_o, exp_pop_addr);
            check("pop_rdata", rdata_o, mem_word(exp_pop_addr));
            $display("[TB] pop addr=%h rdata=%h", addr_o, rdata_o);
            exp_pop_addr += 32'd4;
            pops++;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            bus.instr_rvalid = 1'b1;
            bus.instr_rdata  = mem_word(mq[0].addr);
        end else begin
            bus.instr_rvalid = 1'b0;
            bus.instr_rdata  = '0;
        end
    endtask

    task automatic start_stream(input logic [31:0] target);
        exp_req_addr = target;
        exp_pop_addr = target;
        grants = 0;
        pops = 0;
        req_i = 1'b1;
        branch_i = 1'b1;
        addr_i = target;
        auto_cycle();
        branch_i = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        req_i = 1'b0;
        ready_i = 1'b1;
        n = 0;
        while ((busy_o || valid_o || mq.size() > 0) && n < 30) begin
            auto_cycle();
            n++;
        end
        check({name, "_drain_timeout"}, 32'(n < 30), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    initial begin
        // req br addr rdy gnt rv rdata | req iaddr busy valid addr rdata
        vecs[0]  = '{0,0,32'h0,  0,0,0,32'h0,         0,32'h000,0,0,32'h0,  32'h0};
        vecs[1]  = '{1,1,32'h103,0,1,0,32'h0,         1,32'h100,1,0,32'h0,  32'h0};
        vecs[2]  = '{1,0,32'h0,  0,1,0,32'h0,         1,32'h104,1,0,32'h0,  32'h0};
        vecs[3]  = '{1,0,32'h0,  0,1,1,32'h1111_0000, 0,32'h108,1,0,32'h0,  32'h0};
        vecs[4]  = '{1,0,32'h0,  1,1,1,32'h2222_0001, 1,32'h108,1,1,32'h100,32'h1111_0000};
        vecs[5]  = '{0,0,32'h0,  0,1,1,32'h3333_0002, 0,32'h10C,1,1,32'h104,32'h2222_0001};
        vecs[6]  = '{0,0,32'h0,  1,0,0,32'h0,         0,32'h10C,0,1,32'h104,32'h2222_0001};
        vecs[7]  = '{0,0,32'h0,  1,0,0,32'h0,         0,32'h10C,0,1,32'h108,32'h3333_0002};
        vecs[8]  = '{1,0,32'h0,  0,0,0,32'h0,         1,32'h10C,1,0,32'h0,  32'h0};
        vecs[9]  = '{0,0,32'h0,  0,0,0,32'h0,         1,32'h10C,1,0,32'h0,  32'h0};
        vecs[10] = '{0,1,32'h300,0,0,0,32'h0,         1,32'h300,1,0,32'h0,  32'h0};
        vecs[11] = '{0,0,32'h0,  0,1,0,32'h0,         1,32'h300,1,0,32'h0,  32'h0};
        vecs[12] = '{0,0,32'h0,  0,0,1,32'h4444_0003, 0,32'h304,1,0,32'h0,  32'h0};
        vecs[13] = '{0,0,32'h0,  0,0,0,32'h0,         0,32'h304,0,1,32'h300,32'h4444_0003};
        vecs[14] = '{1,1,32'h200,1,1,0,32'h0,         1,32'h200,1,1,32'h300,32'h4444_0003};
        vecs[15] = '{1,0,32'h0,  0,1,0,32'h0,         1,32'h204,1,0,32'h0,  32'h0};
        vecs[16] = '{1,1,32'h803,0,1,0,32'h0,         0,32'h800,1,0,32'h0,  32'h0};
        vecs[17] = '{1,0,32'h0,  0,1,1,32'hDEAD_0200, 0,32'h800,1,0,32'h0,  32'h0};
        vecs[18] = '{1,0,32'h0,  0,1,1,32'hDEAD_0204, 1,32'h800,1,0,32'h0,  32'h0};
        vecs[19] = '{0,0,32'h0,  0,0,1,32'h5555_0800, 0,32'h804,1,0,32'h0,  32'h0};
        vecs[20] = '{0,0,32'h0,  1,0,0,32'h0,         0,32'h804,0,1,32'h800,32'h5555_0800};
        vecs[21] = '{0,0,32'h0,  0,0,0,32'h0,         0,32'h804,0,0,32'h0,  32'h0};

        bus.instr_gnt = 1'b0;
        bus.instr_rvalid = 1'b0;
        bus.instr_rdata = '0;
`ifdef ZR_PREFETCH_ERR_EN
        bus.instr_err = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req", 32'(bus.instr_req), 32'd0);
        check("rst_iaddr", bus.instr_addr, 32'h0);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_rdata", rdata_o, 32'h0);
        check("rst_addr", addr_o, 32'h0);
        check("rst_busy", 32'(busy_o), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 22; i++) begin
            req_i = vecs[i].req;
            branch_i = vecs[i].br;
            addr_i = vecs[i].addr;
            ready_i = vecs[i].rdy;
            bus.instr_gnt = vecs[i].gnt;
            bus.instr_rvalid = vecs[i].rv;
            bus.instr_rdata = vecs[i].rdata;
            @(negedge clk);
            $display("[TB] vec %0d req=%b iaddr=%h valid=%b addr=%h busy=%b",
                     i, bus.instr_req, bus.instr_addr, valid_o, addr_o, busy_o);
            check($sformatf("vec%0d_req", i), 32'(bus.instr_req), 32'(vecs[i].e_req));
            check($sformatf("vec%0d_iaddr", i), bus.instr_addr, vecs[i].e_iaddr);
            check($sformatf("vec%0d_busy", i), 32'(busy_o), 32'(vecs[i].e_busy));
            check($sformatf("vec%0d_valid", i), 32'(valid_o), 32'(vecs[i].e_valid));
            if (vecs[i].e_valid) begin
                check($sformatf("vec%0d_addr", i), addr_o, vecs[i].e_addr);
                check($sformatf("vec%0d_rdata", i), rdata_o, vecs[i].e_rdata);
            end
            @(posedge clk);
            #1;
        end
        req_i = 1'b0;
        branch_i = 1'b0;
        bus.instr_rvalid = 1'b0;
        bus.instr_rdata = '0;
        bus.instr_gnt = 1'b1;

        // Streaming fetch with a one-cycle memory response: one word per cycle after the fill.
        ready_i = 1'b1;
        start_stream(32'h100);
        for (int i = 0; i < 16; i++) begin
            auto_cycle();
            check($sformatf("stream_valid%0d", i), 32'(valid_o), 32'd1);
        end
        drain("stream");
        check("stream_pops_eq_grants", 32'(pops), 32'(grants));

        // With the core stalled, the FIFO reservation allows exactly DEPTH grants.
        ready_i = 1'b0;
        start_stream(32'h100);
        for (int i = 0; i < 11; i++) auto_cycle();
        check("full_grants", 32'(grants), 32'd4);
        check("full_req_low", 32'(bus.instr_req), 32'd0);
        check("full_valid", 32'(valid_o), 32'd1);
        drain("full");
        check("full_pops", 32'(pops), 32'd4);

        // The address wraps from the top of the address space back to 0.
        ready_i = 1'b1;
        start_stream(32'hFFFF_FFF8);
        for (int i = 0; i < 10 && grants < 4; i++) auto_cycle();
        check("wrap_grants", 32'(grants), 32'd4);
        drain("wrap");
        check("wrap_pops", 32'(pops), 32'(grants));

`ifdef ZR_PREFETCH_ERR_EN
        // An error response blocks further issue until a branch restarts the fetch.
        bus.instr_rvalid = 1'b0;
        ready_i = 1'b0;
        req_i = 1'b1; branch_i = 1'b1; addr_i = 32'h400; bus.instr_gnt = 1'b1;
        @(negedge clk);
        check("err_req0", 32'(bus.instr_req), 32'd1);
        check("err_iaddr0", bus.instr_addr, 32'h400);
        @(posedge clk); #1;
        req_i = 1'b0; branch_i = 1'b0; bus.instr_gnt = 1'b0;
        bus.instr_rvalid = 1'b1; bus.instr_rdata = 32'h0BAD_0400; bus.instr_err = 1'b1;
        @(posedge clk); #1;
        req_i = 1'b1; bus.instr_gnt = 1'b1; bus.instr_rvalid = 1'b0; bus.instr_err = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("err_blocked_req", 32'(bus.instr_req), 32'd0);
            check("err_valid", 32'(valid_o), 32'd1);
            check("err_addr", addr_o, 32'h400);
            check("err_flag", 32'(err_o), 32'd1);
            @(posedge clk); #1;
        end
        branch_i = 1'b1; addr_i = 32'h500; ready_i = 1'b1;
        @(negedge clk);
        check("err_restart_req", 32'(bus.instr_req), 32'd1);
        check("err_restart_iaddr", bus.instr_addr, 32'h500);
        @(posedge clk); #1;
        branch_i = 1'b0; req_i = 1'b0; bus.instr_gnt = 1'b0;
        bus.instr_rvalid = 1'b1; bus.instr_rdata = 32'h600D_0500;
        @(posedge clk); #1;
        bus.instr_rvalid = 1'b0;
        @(negedge clk);
        check("err_after_valid", 32'(valid_o), 32'd1);
        check("err_after_addr", addr_o, 32'h500);
        check("err_after_flag", 32'(err_o), 32'd0);
        @(posedge clk); #1;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
